dmem_arbiter: RTL

//  Shares one synchronous-read data memory (1-cycle BRAM) between the CPU data port and a host port
//  (program loader/debug). Sits between arm_cpu MemWrite/ALUResult/WriteData/ReadData and the BRAM.

---
 rtl/arm_mem_pkg.sv | 24 ++
 rtl/arb2_select.sv | 31 +++
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared encodings for the data-memory arbiter.
//   Contents: FSM state encoding (state_e), port-ownership encoding (owner_e),
//   default memory geometry, and a helper returning the opposite port.
package arm_mem_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    function automatic owner_e other_port(input owner_e o);
        return (o == OWN_CPU) ? OWN_HOST : OWN_CPU;
    endfunction

endpackage

// File: rtl/arb2_select.sv
// arb2_select: combinational two-way grant selector for the data-memory arbiter.
//   Macro: DMEM_ARB_RR_EN defined -> round-robin on contention (grant the port that did
//          not win last time); undefined -> fixed priority, CPU wins contention.
//   Ports:
//     cpu_req_i     in   CPU port request
//     host_req_i    in   host port request
//     last_grant_i  in   port granted most recently
//     winner_o      out  selected port (meaningful only when a request is present)
module arb2_select
    import arm_mem_pkg::*;
(
    input  logic   cpu_req_i,
    input  logic   host_req_i,
    input  owner_e last_grant_i,
    output owner_e winner_o
);

`ifdef DMEM_ARB_RR_EN
    assign winner_o = (cpu_req_i && host_req_i) ? other_port(last_grant_i)
                    : cpu_req_i                 ? OWN_CPU
                    : host_req_i                ? OWN_HOST
                    :                             last_grant_i;
`else
    // With no request the value is irrelevant; last_grant_i is returned so the
    // history input stays connected in this mode too.
    assign winner_o = cpu_req_i  ? OWN_CPU
                    : host_req_i ? OWN_HOST
                    :              last_grant_i;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one 1-cycle synchronous-read data memory between the CPU data port and a host port.
//   Macro: DMEM_ARB_RR_EN selects round-robin arbitration (default: fixed CPU priority).
//   Each access runs IDLE -> ISSUE -> RESP; the requester's ack pulses two cycles after its request is seen.
//   Ports:
//     clk_i                      in   system clock, rising edge
//     rst_ni                     in   asynchronous active-low reset
//     cpu_req_i / host_req_i     in   access request, level, held until ack
//     cpu_we_i / host_we_i       in   1 = write, 0 = read
//     cpu_addr_i / host_addr_i   in   word address
//     cpu_wdata_i / host_wdata_i in   write data
//     cpu_rdata_o / host_rdata_o out  read data, valid while the matching ack is high, else 0
//     cpu_ack_o / host_ack_o     out  one-cycle completion pulse
//     cpu_stall_o / host_stall_o out  req & ~ack, combinational
//     mem_en_o, mem_we_o         out  registered memory enable / write enable
//     mem_addr_o, mem_wdata_o    out  registered memory address / write data
//     mem_rdata_i                in   memory read data, valid the cycle after mem_en_o
module dmem_arbiter
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ack_o,
    output logic              cpu_stall_o,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              host_ack_o,
    output logic              host_stall_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_grant_q, last_grant_d;
    owner_e            winner;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              host_ack_q, host_ack_d;

    arb2_select u_sel (
        .cpu_req_i    (cpu_req_i),
        .host_req_i   (host_req_i),
        .last_grant_i (last_grant_q),
        .winner_o     (winner)
    );

    // Arbitration happens only in IDLE, so a request still high during its own
    // ack (RESP) is never granted a second time.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_ack_d    = 1'b0;
        host_ack_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req_i || host_req_i) begin
                    state_d      = ST_ISSUE;
                    owner_d      = winner;
                    last_grant_d = winner;
                    mem_en_d     = 1'b1;
                    mem_we_d     = (winner == OWN_CPU) ? cpu_we_i    : host_we_i;
                    mem_addr_d   = (winner == OWN_CPU) ? cpu_addr_i  : host_addr_i;
                    mem_wdata_d  = (winner == OWN_CPU) ? cpu_wdata_i : host_wdata_i;
                end
            end
            ST_ISSUE: begin
                // Memory commits/samples at this edge; ack is registered so it
                // lines up with the read data arriving in RESP.
                state_d    = ST_RESP;
                cpu_ack_d  = (owner_q == OWN_CPU);
                host_ack_d = (owner_q == OWN_HOST);
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_CPU;
            last_grant_q <= OWN_HOST;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            host_ack_q   <= host_ack_d;
        end
    end

    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign cpu_ack_o    = cpu_ack_q;
    assign host_ack_o   = host_ack_q;
    // Read data is steered only to the acked owner; the other port sees zero.
    assign cpu_rdata_o  = cpu_ack_q  ? mem_rdata_i : '0;
    assign host_rdata_o = host_ack_q ? mem_rdata_i : '0;
    assign cpu_stall_o  = cpu_req_i  & ~cpu_ack_q;
    assign host_stall_o = host_req_i & ~host_ack_q;

endmodule
